// File: rtl/mux_rr_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_rr_arbiter_if                                                  |
// | Requester-side request/data bus and arbiter-side grant/mux result. |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface mux_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] data_in;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       dout;
    logic       dout_valid;

    modport master (
        output req,
        output data_in,
        input  gnt,
        input  sel,
        input  dout,
        input  dout_valid
    );

    modport slave (
        input  req,
        input  data_in,
        output gnt,
        output sel,
        output dout,
        output dout_valid
    );
endinterface
`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mux_rr_arbiter                                                     |
// | 8-way round-robin arbiter driving a registered 8:1 data-bit mux.   |
// | Optional owner timeout: define MUX_ARB_TIMEOUT_EN.                 |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module mux_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    mux_rr_arbiter_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("mux_rr_arbiter: HOLD_MAX must be within 2..255");
    end

    // Returns {found, index} of the first set bit at or after start, wrapping 7->0.
    function automatic logic [3:0] f_pick(input logic [7:0] r, input logic [2:0] start);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    state_t     state_q, state_d;
    logic [7:0] gnt_q, gnt_d;
    logic [2:0] sel_q, sel_d;
    logic [2:0] ptr_q, ptr_d;
    logic       dout_q, dout_d;
    logic       dout_valid_q, dout_valid_d;

    logic [7:0] w_others;
    logic [3:0] w_pick_idle;
    logic [3:0] w_pick_rel;
    logic       w_release;

`ifdef MUX_ARB_TIMEOUT_EN
    localparam logic [7:0] c_HOLD_LAST = 8'(HOLD_MAX - 1);
    logic [7:0] hold_q, hold_d;
`endif

    assign w_others    = bus.req & ~(8'h01 << sel_q);
    assign w_pick_idle = f_pick(bus.req, ptr_q);
    assign w_pick_rel  = f_pick(w_others, sel_q + 3'd1);

`ifdef MUX_ARB_TIMEOUT_EN
    assign w_release = ~bus.req[sel_q] | ((hold_q >= c_HOLD_LAST) & (|w_others));
`else
    assign w_release = ~bus.req[sel_q];
`endif

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        sel_d        = sel_q;
        ptr_d        = ptr_q;
        dout_d       = 1'b0;
        dout_valid_d = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
        hold_d       = hold_q;
`endif
        case (state_q)
            S_IDLE: begin
                gnt_d = 8'h00;
                if (w_pick_idle[3]) begin
                    state_d = S_GRANT;
                    sel_d   = w_pick_idle[2:0];
                    gnt_d   = 8'h01 << w_pick_idle[2:0];
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_d  = 8'd0;
`endif
                end
            end
            S_GRANT: begin
                dout_d       = bus.data_in[sel_q];
                dout_valid_d = 1'b1;
                if (w_release) begin
                    // Owner is excluded from the re-arbitration so hand-over needs no idle cycle.
                    ptr_d = sel_q + 3'd1;
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_d = 8'd0;
`endif
                    if (w_pick_rel[3]) begin
                        sel_d = w_pick_rel[2:0];
                        gnt_d = 8'h01 << w_pick_rel[2:0];
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = 8'h00;
                    end
                end
`ifdef MUX_ARB_TIMEOUT_EN
                else if (hold_q < c_HOLD_LAST) begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= 8'h00;
            sel_q        <= 3'd0;
            ptr_q        <= 3'd0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q       <= 8'd0;
`endif
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            sel_q        <= sel_d;
            ptr_q        <= ptr_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q       <= hold_d;
`endif
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.sel        = sel_q;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// Bench for mux_rr_arbiter: directed scenarios plus random traffic,
// each edge compared against an owner/pointer model of the arbitration rules.
module tb_mux_rr_arbiter;

    localparam int HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit M_TO = 1'b1;
`else
    localparam bit M_TO = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux_rr_arbiter_if bus ();

    mux_rr_arbiter #(.HOLD_MAX(HOLD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Model state: owner index or -1 when nobody holds the bus.
    int   m_owner, m_ptr, m_sel, m_hold;
    logic m_dout, m_valid;

    function automatic int pick(input logic [7:0] r, input int p);
        for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_ptr = 0; m_sel = 0; m_hold = 0;
        m_dout  = 1'b0; m_valid = 1'b0;
    endtask

    task automatic model_edge();
        logic [7:0] r, d, others;
        int  w;
        bit  rel;
        r = bus.req;
        d = bus.data_in;
        m_valid = (m_owner >= 0);
        m_dout  = (m_owner >= 0) ? d[m_sel] : 1'b0;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin m_owner = w; m_sel = w; m_hold = 0; end
        end else begin
            others = r & ~(8'(1) << m_owner);
            rel = !r[m_owner] || (M_TO && m_hold >= HOLD - 1 && others != 8'h00);
            if (rel) begin
                m_ptr  = (m_owner + 1) % 8;
                m_hold = 0;
                w = pick(others, m_ptr);
                if (w >= 0) begin m_owner = w; m_sel = w; end
                else m_owner = -1;
            end else if (M_TO && m_hold < HOLD - 1) begin
                m_hold = m_hold + 1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all(input string tag);
        logic [7:0] eg;
        eg = (m_owner >= 0) ? 8'(1 << m_owner) : 8'h00;
        chk({tag, "_gnt"},  bus.gnt, eg);
        chk({tag, "_sel"},  {5'd0, bus.sel}, 8'(m_sel));
        chk({tag, "_dout"}, {7'd0, bus.dout}, {7'd0, m_dout});
        chk({tag, "_dv"},   {7'd0, bus.dout_valid}, {7'd0, m_valid});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        cmp_all(tag);
    endtask

    // Assert reset between edges and check the outputs clear without a clock.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        cmp_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bus.req     = 8'hFF;
        bus.data_in = 8'h00;
        model_reset();
        #1;
        cmp_all("rst");

        // First arbitration after reset starts at index 0.
        @(negedge clk);
        rst_n = 1'b1;
        step("r26a");
        chk("r26_gnt", bus.gnt, 8'h01);
        step("r26b");
        chk("r26_dv", {7'd0, bus.dout_valid}, 8'h01);

        // Back-to-back hand-over 2 -> 5.
        bus.req = 8'h24;
        step("r27a");
        chk("r27_gnt2", bus.gnt, 8'h04);
        step("r27b");
        step("r27c");
        bus.req = 8'h20;
        step("r27d");
        chk("r27_gnt5", bus.gnt, 8'h20);
        chk("r27_sel5", {5'd0, bus.sel}, 8'd5);

        // Wrap from owner 7 to 0, then drain to idle.
        bus.req = 8'h80;
        step("r28a");
        chk("r28_gnt7", bus.gnt, 8'h80);
        bus.req = 8'h81;
        step("r28b");
        bus.req = 8'h01;
        step("r28c");
        chk("r28_gnt0", bus.gnt, 8'h01);
        bus.req = 8'h00;
        step("r28d");
        chk("r28_idle", bus.gnt, 8'h00);
        step("r28e");
        chk("r28_dv0", {7'd0, bus.dout_valid}, 8'h00);

        // Data path through requester 3.
        bus.req     = 8'h08;
        bus.data_in = 8'h08;
        step("r29a");
        chk("r29_gnt3", bus.gnt, 8'h08);
        step("r29b");
        chk("r29_d1", {7'd0, bus.dout}, 8'h01);
        bus.data_in = 8'h00;
        step("r29c");
        chk("r29_d0", {7'd0, bus.dout}, 8'h00);

        // Asynchronous reset mid-grant, then re-grant from index 0.
        bus.req = 8'hFF;
        pulse_reset("r30rst");
        step("r30a");
        chk("r30_gnt0", bus.gnt, 8'h01);

`ifdef MUX_ARB_TIMEOUT_EN
        bus.req = 8'h00;
        pulse_reset("r31rst");
        bus.req = 8'h03;
        for (int i = 0; i < 12; i++) begin
            step("r31alt");
            chk("r31_alt", bus.gnt, ((i / 4) % 2 == 1) ? 8'h02 : 8'h01);
        end
        bus.req = 8'h01;
        for (int i = 0; i < 8; i++) begin
            step("r31hold");
            chk("r31_hold", bus.gnt, 8'h01);
        end
`endif

        // Random traffic; requests change only sometimes so tenures last a while.
        bus.req = 8'h00;
        pulse_reset("rnd_rst");
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) bus.req = 8'($urandom);
            bus.data_in = 8'($urandom);
            step("rnd");
            if (i == 200) pulse_reset("rnd_mid");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16, sets the maximum consecutive grant cycles before preemption; legal range 2..255.
REQ-002 Port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-003 Port rst_n, input, 1, reset, asynchronous and active-low.
REQ-004 Port req, input, 8, per-requester access request; bit i belongs to requester i.
REQ-005 Port data_in, input, 8, per-requester data bit; bit i is driven by requester i.
REQ-006 Port gnt, output, 8, one-hot grant, or all zero when no requester is granted.
REQ-007 Port sel, output, 3, binary index of the current or last owner; drives the 8:1 mux select.
REQ-008 Port dout, output, 1, registered value of data_in[sel].
REQ-009 Port dout_valid, output, 1, marks dout as carrying granted data.

Function
REQ-010 Two-state FSM: IDLE (gnt=0) and GRANT (exactly one gnt bit set); all outputs registered.
REQ-011 Round-robin pointer ptr (3 bits): search begins at ptr and wraps 7->0; first set req bit wins.
REQ-012 IDLE: any req bit sampled high at edge N -> GRANT, gnt/sel updated at edge N; no req -> stay IDLE.
REQ-013 GRANT, req[sel]=1 (no preemption): hold gnt, sel, and owner unchanged.
REQ-014 GRANT, req[sel]=0 at edge N: ptr <= sel+1 mod 8; re-arbitrate the same edge over current req with owner excluded; winner -> new grant at edge N (no bubble); no winner -> IDLE with gnt=0.
REQ-015 sel keeps the last owner's index in IDLE.
REQ-016 dout <= data_in[sel] and dout_valid <= 1 on every edge where state is GRANT (one-cycle latency from gnt to dout).
REQ-017 In IDLE: dout <= 0, dout_valid <= 0.
REQ-018 Simultaneous requests: the lowest index at or after ptr (with wrap) wins; other requests wait and are not lost.
REQ-019 A requester dropping req in the same cycle it would win is simply not selected.
REQ-020 Starvation bound, no preemption: each pending requester is granted within 7 grant tenures.

Reset
REQ-021 rst_n low, asynchronously: state=IDLE, gnt=8'h00, sel=3'd0, ptr=3'd0, dout=0, dout_valid=0, hold counter=0.
REQ-022 Reset asserted mid-grant clears all outputs immediately, with no clock edge needed.
REQ-023 After rst_n deasserts, the first arbitration starts from index 0.

Configuration
REQ-024 Macro MUX_ARB_TIMEOUT_EN defined: an 8-bit hold counter runs.
  - Counter clears on each new grant and increments each GRANT cycle.
  - When it reaches HOLD_MAX-1 and any other req bit is set, the owner is preempted at the next edge: ptr <= sel+1, and re-arbitration follows REQ-014 with the owner excluded.
  - With no other requester, the counter saturates and the grant is held.
REQ-025 Macro MUX_ARB_TIMEOUT_EN undefined: no counter is present and the grant is held until the owner drops req.

Verification
REQ-026 Reset with req=8'hFF, then release rst_n -> gnt=8'h01 and sel=0 after the first edge; dout_valid=1 one edge later.
REQ-027 req=8'h24 held, then req[2] dropped -> gnt 8'h04 -> 8'h20 on the same edge (sel 2->5), with no IDLE cycle.
REQ-028 Owner 7 releases, req=8'h81 -> ptr wraps to 0, gnt=8'h01; req then 8'h00 -> IDLE with gnt=8'h00 and dout_valid=0 next edge.
REQ-029 Granted to 3 with data_in=8'h08 -> dout=1 one edge after gnt; data_in=8'h00 -> dout=0 the next edge.
REQ-030 rst_n pulsed low mid-GRANT between edges -> gnt=0, dout_valid=0 immediately; re-grant starts from index 0.
REQ-031 With MUX_ARB_TIMEOUT_EN defined, HOLD_MAX=4, and req=8'h03 held -> gnt alternates 8'h01/8'h02 every 4 cycles; with req=8'h01 only, gnt=8'h01 persists.
